// File: rtl/host_dma_channel.sv
// Host-side DMA cache-line channel: a read path that fetches lines from host memory into an FWFT
// FIFO, and an independent write path that drains a line FIFO to consecutive host addresses.
module host_dma_channel #(
  parameter int unsigned CL_ADDR_WIDTH = 32,
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_start,
  input  logic [CL_ADDR_WIDTH-1:0] rd_addr,
  input  logic [CL_ADDR_WIDTH-1:0] rd_size,
  input  logic                     wr_start,
  input  logic [CL_ADDR_WIDTH-1:0] wr_addr,
  input  logic [CL_ADDR_WIDTH-1:0] wr_size,
  output logic                     empty,
  output logic [CL_SIZE_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     full,
  input  logic [CL_SIZE_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     mem_rd_req,
  output logic [CL_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                     mem_rd_valid,
  input  logic [CL_SIZE_WIDTH-1:0] mem_rd_data,
  output logic                     mem_wr_req,
  output logic [CL_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [CL_SIZE_WIDTH-1:0] mem_wr_data,
  input  logic                     mem_wr_ack,
  output logic                     rd_done,
  output logic                     wr_done,
  output logic                     wr_overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CL_ADDR_WIDTH-1:0] Stride = CL_ADDR_WIDTH'(CL_SIZE_WIDTH / 8);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RdIdle, RdReq, RdWait} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrWaitData, WrReq} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;

  logic [CL_SIZE_WIDTH-1:0] rf_mem_q [FIFO_DEPTH];
  logic [CL_SIZE_WIDTH-1:0] wf_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rf_wptr_q, rf_wptr_d, rf_rptr_q, rf_rptr_d;
  logic [PtrW-1:0] wf_wptr_q, wf_wptr_d, wf_rptr_q, wf_rptr_d;
  logic [CntW-1:0] rf_cnt_q, rf_cnt_d, wf_cnt_q, wf_cnt_d;
  logic            rf_push, rf_pop, wf_push, wf_pop;

  logic [CL_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, rd_size_q, rd_size_d, rd_cnt_q, rd_cnt_d;
  logic [CL_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, wr_size_q, wr_size_d, wr_cnt_q, wr_cnt_d;
  logic [CL_ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [CL_SIZE_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic rd_done_q, rd_done_d, wr_done_q, wr_done_d, wr_ovf_q, wr_ovf_d;

  assign empty       = (rf_cnt_q == '0);
  assign full        = (wf_cnt_q == DepthC);
  assign rf_pop      = rd_en && !empty;
  assign rd_data     = empty ? '0 : rf_mem_q[rf_rptr_q];
  // A drain-pop in the same cycle frees the slot, so a push against a full FIFO is still taken.
  assign wf_push     = wr_en && (!full || wf_pop);
  assign mem_rd_addr = mem_rd_req ? rd_addr_q : '0;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign rd_done     = rd_done_q;
  assign wr_done     = wr_done_q;
  assign wr_overflow = wr_ovf_q;

  always_comb begin
    rf_wptr_d = rf_wptr_q;
    rf_rptr_d = rf_rptr_q;
    rf_cnt_d  = rf_cnt_q;
    wf_wptr_d = wf_wptr_q;
    wf_rptr_d = wf_rptr_q;
    wf_cnt_d  = wf_cnt_q;
    if (rf_push) rf_wptr_d = rf_wptr_q + PtrW'(1);
    if (rf_pop)  rf_rptr_d = rf_rptr_q + PtrW'(1);
    if (rf_push && !rf_pop) rf_cnt_d = rf_cnt_q + CntW'(1);
    if (!rf_push && rf_pop) rf_cnt_d = rf_cnt_q - CntW'(1);
    if (wf_push) wf_wptr_d = wf_wptr_q + PtrW'(1);
    if (wf_pop)  wf_rptr_d = wf_rptr_q + PtrW'(1);
    if (wf_push && !wf_pop) wf_cnt_d = wf_cnt_q + CntW'(1);
    if (!wf_push && wf_pop) wf_cnt_d = wf_cnt_q - CntW'(1);
  end

  // Read FSM: one outstanding request, issued only when the line FIFO has room.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    rd_cnt_d   = rd_cnt_q;
    rd_done_d  = rd_done_q;
    mem_rd_req = 1'b0;
    rf_push    = 1'b0;
    unique case (rd_state_q)
      RdIdle: begin
        if (rd_start) begin
          rd_addr_d = rd_addr;
          rd_size_d = rd_size;
          rd_cnt_d  = '0;
          rd_done_d = (rd_size == '0);
          if (rd_size != '0) rd_state_d = RdReq;
        end
      end
      RdReq: begin
        if (rf_cnt_q < DepthC) begin
          mem_rd_req = 1'b1;
          rd_state_d = RdWait;
        end
      end
      RdWait: begin
        if (mem_rd_valid) begin
          rf_push   = 1'b1;
          rd_addr_d = rd_addr_q + Stride;
          rd_cnt_d  = rd_cnt_q + CL_ADDR_WIDTH'(1);
          if (rd_cnt_d == rd_size_q) begin
            rd_done_d  = 1'b1;
            rd_state_d = RdIdle;
          end else begin
            rd_state_d = RdReq;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_addr_d     = wr_addr_q;
    wr_size_d     = wr_size_q;
    wr_cnt_d      = wr_cnt_q;
    wr_done_d     = wr_done_q;
    wr_ovf_d      = wr_ovf_q | (wr_en && full && !wf_pop);
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_req    = 1'b0;
    wf_pop        = 1'b0;
    unique case (wr_state_q)
      WrIdle: begin
        if (wr_start) begin
          wr_addr_d = wr_addr;
          wr_size_d = wr_size;
          wr_cnt_d  = '0;
          wr_done_d = (wr_size == '0);
          if (wr_size != '0) wr_state_d = WrWaitData;
        end
      end
      WrWaitData: begin
        if (wf_cnt_q != '0) begin
          mem_wr_data_d = wf_mem_q[wf_rptr_q];
          mem_wr_addr_d = wr_addr_q;
          wr_state_d    = WrReq;
        end
      end
      WrReq: begin
        mem_wr_req = 1'b1;
        if (mem_wr_ack) begin
          wf_pop    = 1'b1;
          wr_addr_d = wr_addr_q + Stride;
          wr_cnt_d  = wr_cnt_q + CL_ADDR_WIDTH'(1);
          if (wr_cnt_d == wr_size_q) begin
            wr_done_d  = 1'b1;
            wr_state_d = WrIdle;
          end else begin
            wr_state_d = WrWaitData;
          end
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rf_push) rf_mem_q[rf_wptr_q] <= mem_rd_data;
    if (wf_push) wf_mem_q[wf_wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q    <= RdIdle;
      wr_state_q    <= WrIdle;
      rf_wptr_q     <= '0;
      rf_rptr_q     <= '0;
      rf_cnt_q      <= '0;
      wf_wptr_q     <= '0;
      wf_rptr_q     <= '0;
      wf_cnt_q      <= '0;
      rd_addr_q     <= '0;
      rd_size_q     <= '0;
      rd_cnt_q      <= '0;
      wr_addr_q     <= '0;
      wr_size_q     <= '0;
      wr_cnt_q      <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      rd_done_q     <= 1'b0;
      wr_done_q     <= 1'b0;
      wr_ovf_q      <= 1'b0;
    end else begin
      rd_state_q    <= rd_state_d;
      wr_state_q    <= wr_state_d;
      rf_wptr_q     <= rf_wptr_d;
      rf_rptr_q     <= rf_rptr_d;
      rf_cnt_q      <= rf_cnt_d;
      wf_wptr_q     <= wf_wptr_d;
      wf_rptr_q     <= wf_rptr_d;
      wf_cnt_q      <= wf_cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_size_q     <= rd_size_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_addr_q     <= wr_addr_d;
      wr_size_q     <= wr_size_d;
      wr_cnt_q      <= wr_cnt_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_done_q     <= rd_done_d;
      wr_done_q     <= wr_done_d;
      wr_ovf_q      <= wr_ovf_d;
    end
  end

endmodule

// File: doc/host_dma_channel.md
Name: host_dma_channel

Overview:
- Host-side end of the DMA cache-line interface; the word-serial DMA controller on the CPU side sits opposite it.
- Read path fetches `rd_size` cache lines from host memory into a first-word-fall-through (FWFT) line FIFO, exposed as `empty`/`rd_data`/`rd_en`.
- Write path accepts lines on `wr_data`/`wr_en` (with `full` backpressure) into a second line FIFO and drains them to host memory at consecutive line addresses.
- Both paths run concurrently and independently.

Parameters:
CL_ADDR_WIDTH, 32, width of host byte addresses and of line-count fields
CL_SIZE_WIDTH, 512, cache-line width in bits; address stride is CL_SIZE_WIDTH/8 bytes
FIFO_DEPTH, 4, entries per line FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_start  in  1  one-cycle pulse: begin read transfer
rd_addr  in  CL_ADDR_WIDTH  host byte base address for read, latched on rd_start
rd_size  in  CL_ADDR_WIDTH  number of lines to read, latched on rd_start
wr_start  in  1  one-cycle pulse: begin write transfer
wr_addr  in  CL_ADDR_WIDTH  host byte base address for write, latched on wr_start
wr_size  in  CL_ADDR_WIDTH  number of lines to write, latched on wr_start
empty  out  1  read FIFO empty
rd_data  out  CL_SIZE_WIDTH  head of read FIFO (FWFT)
rd_en  in  1  pop read FIFO head
full  out  1  write FIFO full
wr_data  in  CL_SIZE_WIDTH  line to push
wr_en  in  1  push wr_data
mem_rd_req  out  1  host memory line read request
mem_rd_addr  out  CL_ADDR_WIDTH  read request address
mem_rd_valid  in  1  read response valid
mem_rd_data  in  CL_SIZE_WIDTH  read response line
mem_wr_req  out  1  host memory line write request, held until ack
mem_wr_addr  out  CL_ADDR_WIDTH  write address
mem_wr_data  out  CL_SIZE_WIDTH  write line
mem_wr_ack  in  1  write accepted
rd_done  out  1  sticky: all rd_size lines delivered into read FIFO
wr_done  out  1  sticky: all wr_size lines acknowledged by host memory
wr_overflow  out  1  sticky: wr_en seen while full

Behaviour:
- Reset (async, rst_n=0): both FIFOs emptied; `empty`=1, `full`=0, `rd_data`=0, all mem_* outputs 0, `rd_done`=`wr_done`=`wr_overflow`=0; both FSMs return to IDLE. An in-flight read response arriving after reset is discarded.
- Read FSM: RD_IDLE -> RD_REQ -> RD_WAIT -> RD_REQ ... -> RD_IDLE.
  - RD_IDLE: on `rd_start`, latch addr/size, clear `rd_done`. If size=0, set `rd_done` next cycle and stay in RD_IDLE; otherwise go to RD_REQ.
  - RD_REQ: when read-FIFO free entries >= 1, assert `mem_rd_req` for exactly one cycle with the current address, then go to RD_WAIT. At most one request is outstanding.
  - RD_WAIT: on `mem_rd_valid`, push `mem_rd_data`; the entry is visible (`empty`=0) the following cycle. Address += CL_SIZE_WIDTH/8, modulo 2^CL_ADDR_WIDTH (wraps). Count++. If count==size, set `rd_done` and go to RD_IDLE; else go to RD_REQ. `mem_rd_valid` in any other state is ignored.
  - `rd_start` while not in RD_IDLE is ignored.
- Read FIFO: `rd_en` with `empty`=0 pops the head; `rd_data` updates next cycle. `rd_en` with `empty`=1 is ignored. A simultaneous push and pop keeps the count unchanged.
- Write FIFO:
  - `wr_en` with `full`=0 pushes `wr_data`.
  - `wr_en` with `full`=1 drops the data and sets `wr_overflow`.
  - `full` asserts the cycle after the FIFO_DEPTH-th entry is stored.
  - A push and a drain-pop in the same cycle are both honoured, including when full.
- Write FSM: WR_IDLE -> WR_WAIT_DATA <-> WR_REQ -> WR_IDLE.
  - WR_IDLE: `wr_start` latches addr/size and clears `wr_done`. If size=0, set `wr_done` next cycle; otherwise go to WR_WAIT_DATA.
  - WR_WAIT_DATA: when the FIFO is not empty, load the head into `mem_wr_data`/`mem_wr_addr` and go to WR_REQ.
  - WR_REQ: `mem_wr_req`=1 with data and address stable until `mem_wr_ack`. On ack: pop, deassert req next cycle, address += stride (wraps), count++. If count==size, set `wr_done` and go to WR_IDLE; else go to WR_WAIT_DATA.
  - Lines pushed while in WR_IDLE are retained and drained by the next transfer.
- Latency: an unstalled read delivers one line per 2 cycles plus host memory latency. An unstalled write drains one line per 2 cycles plus ack latency.

Test Plan:
- rd_start, rd_addr=0x1000, rd_size=3; memory responds 2 cycles after each req; consumer pops immediately -> mem_rd_addr 0x1000, 0x1040, 0x1080, lines in order, rd_done=1 after third push.
- rd_size=6, no rd_en until rd_done -> stalls after 4 lines with mem_rd_req low; popping 2 lines resumes; total 6 requests, no data loss.
- wr_start, wr_addr=0x5000, wr_size=2; push lines A,B; ack after 3 cycles each -> mem_wr_addr 0x5000 then 0x5040, data A then B, req held stable until ack, wr_done=1.
- Hold mem_wr_ack low, push 5 lines -> full=1 after 4, 5th dropped, wr_overflow=1; release ack -> 4 lines written.
- rd_addr=0xFFFFFFC0, rd_size=2 -> second address 0x00000000; rd_size=0 -> rd_done next cycle with no mem_rd_req.
- Assert rst_n=0 in RD_WAIT, then deliver mem_rd_valid after release -> response ignored, empty=1, all outputs at reset values.
